// File: rtl/minisrc_pkg.sv
// rtl/minisrc_pkg.sv - Mini SRC control unit shared opcodes, class/step encodings and helpers
// Purpose: opcode constants, instruction-class enum and sequencer step encoding
//   shared by the op-class decoder and the control unit.
// Ports: none (package).
package minisrc_pkg;

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_ROR  = 5'b00111;
  localparam logic [4:0] OP_ROL  = 5'b01000;
  localparam logic [4:0] OP_SHR  = 5'b01001;
  localparam logic [4:0] OP_SHRA = 5'b01010;
  localparam logic [4:0] OP_SHL  = 5'b01011;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_ANDI = 5'b01101;
  localparam logic [4:0] OP_ORI  = 5'b01110;
  localparam logic [4:0] OP_DIV  = 5'b01111;
  localparam logic [4:0] OP_MUL  = 5'b10000;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;
  localparam logic [4:0] OP_BR   = 5'b10011;
  localparam logic [4:0] OP_JR   = 5'b10100;
  localparam logic [4:0] OP_IN   = 5'b10110;
  localparam logic [4:0] OP_OUT  = 5'b10111;
  localparam logic [4:0] OP_MFHI = 5'b11000;
  localparam logic [4:0] OP_MFLO = 5'b11001;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  typedef enum logic [3:0] {
    CLS_ALU_R, CLS_ALU_I, CLS_MULDIV, CLS_UNARY, CLS_LD, CLS_LDI, CLS_ST, CLS_BR,
    CLS_JR, CLS_IN, CLS_OUT, CLS_MFHI, CLS_MFLO, CLS_NOP, CLS_HALT, CLS_ILL
  } op_class_t;

  typedef enum logic [3:0] {
    S_RST, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
  } step_t;

  // Maps a step index 0..7 onto its Tn state.
  function automatic step_t t_of(logic [2:0] n);
    case (n)
      3'd0:    return S_T0;
      3'd1:    return S_T1;
      3'd2:    return S_T2;
      3'd3:    return S_T3;
      3'd4:    return S_T4;
      3'd5:    return S_T5;
      3'd6:    return S_T6;
      default: return S_T7;
    endcase
  endfunction

  function automatic step_t step_after(step_t s);
    case (s)
      S_T0:    return S_T1;
      S_T1:    return S_T2;
      S_T2:    return S_T3;
      S_T3:    return S_T4;
      S_T4:    return S_T5;
      S_T5:    return S_T6;
      S_T6:    return S_T7;
      default: return S_T0;
    endcase
  endfunction

  // Immediate forms reuse the ALU opcode of their register counterpart.
  function automatic logic [4:0] imm_alu_op(logic [4:0] op);
    case (op)
      OP_ADDI: return OP_ADD;
      OP_ANDI: return OP_AND;
      default: return OP_OR;
    endcase
  endfunction

endpackage

// File: rtl/minisrc_control_unit_if.sv
// rtl/minisrc_control_unit_if.sv - control bundle between sequencer and Mini SRC datapath
// Purpose: groups instruction/condition/stop inputs and every datapath strobe.
// Modports: master = control unit (drives strobes, reads IR_Data/CON_out/Stop);
//           slave  = datapath side (drives IR_Data/CON_out/Stop, reads strobes).
interface minisrc_control_unit_if;
  logic [31:0] IR_Data;
  logic        CON_out;
  logic        Stop;
  logic PC_in, IR_in, Y_in, Z_in, HI_in, LO_in, MAR_in, MDR_in, OutPort_in, IncPC;
  logic PC_out, Zhigh_out, Zlow_out, HI_out, LO_out, MDR_out, InPort_out, C_out;
  logic Read, Write;
  logic Gra, Grb, Grc, Rin, Rout, BAout;
  logic CON_in;
  logic [4:0] alu_op;
  logic Run;

  modport master (
    input  IR_Data, CON_out, Stop,
    output PC_in, IR_in, Y_in, Z_in, HI_in, LO_in, MAR_in, MDR_in, OutPort_in, IncPC,
    output PC_out, Zhigh_out, Zlow_out, HI_out, LO_out, MDR_out, InPort_out, C_out,
    output Read, Write, Gra, Grb, Grc, Rin, Rout, BAout, CON_in, alu_op, Run
  );

  modport slave (
    output IR_Data, CON_out, Stop,
    input  PC_in, IR_in, Y_in, Z_in, HI_in, LO_in, MAR_in, MDR_in, OutPort_in, IncPC,
    input  PC_out, Zhigh_out, Zlow_out, HI_out, LO_out, MDR_out, InPort_out, C_out,
    input  Read, Write, Gra, Grb, Grc, Rin, Rout, BAout, CON_in, alu_op, Run
  );
endinterface

// File: rtl/minisrc_op_class.sv
// rtl/minisrc_op_class.sv - opcode to instruction class and last execute step
// Purpose: combinational decode of IR opcode bits.
// Ports: opcode (in, 5) ; op_class (out, class enum) ; last_step (out, 3, index of final Tn).
module minisrc_op_class
  import minisrc_pkg::*;
(
  input  logic [4:0] opcode,
  output op_class_t  op_class,
  output logic [2:0] last_step
);

  always_comb begin
    op_class  = CLS_ILL;
    last_step = 3'd3;
    case (opcode)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR, OP_ROL, OP_SHR, OP_SHRA, OP_SHL: begin
        op_class = CLS_ALU_R; last_step = 3'd5;
      end
      OP_ADDI, OP_ANDI, OP_ORI: begin op_class = CLS_ALU_I;  last_step = 3'd5; end
      OP_MUL, OP_DIV:           begin op_class = CLS_MULDIV; last_step = 3'd6; end
      OP_NEG, OP_NOT:           begin op_class = CLS_UNARY;  last_step = 3'd4; end
      OP_LD:                    begin op_class = CLS_LD;     last_step = 3'd7; end
      OP_LDI:                   begin op_class = CLS_LDI;    last_step = 3'd5; end
      OP_ST:                    begin op_class = CLS_ST;     last_step = 3'd7; end
      OP_BR:                    begin op_class = CLS_BR;     last_step = 3'd6; end
      OP_JR:                    op_class = CLS_JR;
      OP_IN:                    op_class = CLS_IN;
      OP_OUT:                   op_class = CLS_OUT;
      OP_MFHI:                  op_class = CLS_MFHI;
      OP_MFLO:                  op_class = CLS_MFLO;
      OP_NOP:                   op_class = CLS_NOP;
      OP_HALT:                  op_class = CLS_HALT;
      default:                  op_class = CLS_ILL;
    endcase
  end

endmodule

// File: rtl/minisrc_control_unit.sv
// rtl/minisrc_control_unit.sv - hardwired Moore sequencer for the Mini SRC datapath
// Purpose: fetch T0-T2, per-class execute T3..T7, HALT on halt/Stop, sync reset via clr.
// Ports: clk (in) ; clr (in, sync active-low) ; bus (minisrc_control_unit_if.master):
//   IR_Data/CON_out/Stop in, all datapath strobes, alu_op and Run out.
module minisrc_control_unit
  import minisrc_pkg::*;
#(
  parameter logic [4:0] ALU_ADD         = 5'b00011,
  parameter bit         HALT_ON_ILLEGAL = 1'b0
) (
  input  logic                          clk,
  input  logic                          clr,
  minisrc_control_unit_if.master        bus
);

  step_t      state, state_next;
  op_class_t  cls;
  logic [2:0] last_step;
  logic [4:0] opcode;
  logic       at_last;
  logic       unused_ir;

  assign opcode = bus.IR_Data[31:27];
  // Register fields below the opcode are consumed by the datapath, not here.
  assign unused_ir = ^bus.IR_Data[26:0];

  minisrc_op_class u_op_class (
    .opcode    (opcode),
    .op_class  (cls),
    .last_step (last_step)
  );

  // last_step is never below 3, so fetch states can never match here.
  assign at_last = (state == t_of(last_step));

  always_ff @(posedge clk) begin
    if (!clr) state <= S_RST;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_RST:  state_next = S_T0;
      S_HALT: state_next = S_HALT;
      default: begin
        if (at_last) begin
          if (cls == CLS_HALT || (cls == CLS_ILL && HALT_ON_ILLEGAL) || bus.Stop)
            state_next = S_HALT;
          else
            state_next = S_T0;
        end else begin
          state_next = step_after(state);
        end
      end
    endcase
  end

  assign bus.Run = (state != S_RST) && (state != S_HALT);

  always_comb begin
    bus.PC_in = 1'b0;      bus.IR_in = 1'b0;     bus.Y_in = 1'b0;       bus.Z_in = 1'b0;
    bus.HI_in = 1'b0;      bus.LO_in = 1'b0;     bus.MAR_in = 1'b0;     bus.MDR_in = 1'b0;
    bus.OutPort_in = 1'b0; bus.IncPC = 1'b0;     bus.PC_out = 1'b0;     bus.Zhigh_out = 1'b0;
    bus.Zlow_out = 1'b0;   bus.HI_out = 1'b0;    bus.LO_out = 1'b0;     bus.MDR_out = 1'b0;
    bus.InPort_out = 1'b0; bus.C_out = 1'b0;     bus.Read = 1'b0;       bus.Write = 1'b0;
    bus.Gra = 1'b0;        bus.Grb = 1'b0;       bus.Grc = 1'b0;        bus.Rin = 1'b0;
    bus.Rout = 1'b0;       bus.BAout = 1'b0;     bus.CON_in = 1'b0;     bus.alu_op = 5'b00000;

    case (state)
      S_T0: begin bus.PC_out = 1'b1; bus.MAR_in = 1'b1; bus.IncPC = 1'b1; bus.Z_in = 1'b1; end
      S_T1: begin bus.Zlow_out = 1'b1; bus.PC_in = 1'b1; bus.Read = 1'b1; bus.MDR_in = 1'b1; end
      S_T2: begin bus.MDR_out = 1'b1; bus.IR_in = 1'b1; end
      S_RST, S_HALT: ;
      default: begin
        case (cls)
          CLS_ALU_R, CLS_ALU_I: begin
            case (state)
              S_T3: begin bus.Grb = 1'b1; bus.Rout = 1'b1; bus.Y_in = 1'b1; end
              S_T4: begin
                bus.Z_in = 1'b1;
                if (cls == CLS_ALU_I) begin
                  bus.C_out  = 1'b1;
                  bus.alu_op = imm_alu_op(opcode);
                end else begin
                  bus.Grc    = 1'b1;
                  bus.Rout   = 1'b1;
                  bus.alu_op = opcode;
                end
              end
              S_T5: begin bus.Zlow_out = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1; end
              default: ;
            endcase
          end
          CLS_MULDIV: begin
            case (state)
              S_T3: begin bus.Gra = 1'b1; bus.Rout = 1'b1; bus.Y_in = 1'b1; end
              S_T4: begin bus.Grb = 1'b1; bus.Rout = 1'b1; bus.Z_in = 1'b1; bus.alu_op = opcode; end
              S_T5: begin bus.Zlow_out = 1'b1; bus.LO_in = 1'b1; end
              S_T6: begin bus.Zhigh_out = 1'b1; bus.HI_in = 1'b1; end
              default: ;
            endcase
          end
          CLS_UNARY: begin
            case (state)
              S_T3: begin bus.Grb = 1'b1; bus.Rout = 1'b1; bus.Z_in = 1'b1; bus.alu_op = opcode; end
              S_T4: begin bus.Zlow_out = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1; end
              default: ;
            endcase
          end
          CLS_LD, CLS_LDI, CLS_ST: begin
            // Effective address = base (or 0 when R0) + C, formed in T3..T5.
            case (state)
              S_T3: begin bus.Grb = 1'b1; bus.BAout = 1'b1; bus.Y_in = 1'b1; end
              S_T4: begin bus.C_out = 1'b1; bus.Z_in = 1'b1; bus.alu_op = ALU_ADD; end
              S_T5: begin
                bus.Zlow_out = 1'b1;
                if (cls == CLS_LDI) begin bus.Gra = 1'b1; bus.Rin = 1'b1; end
                else                bus.MAR_in = 1'b1;
              end
              S_T6: begin
                bus.MDR_in = 1'b1;
                if (cls == CLS_ST) begin bus.Gra = 1'b1; bus.Rout = 1'b1; end
                else               bus.Read = 1'b1;
              end
              S_T7: begin
                if (cls == CLS_ST) bus.Write = 1'b1;
                else begin bus.MDR_out = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1; end
              end
              default: ;
            endcase
          end
          CLS_BR: begin
            case (state)
              S_T3: begin bus.Gra = 1'b1; bus.Rout = 1'b1; bus.CON_in = 1'b1; end
              S_T4: begin bus.PC_out = 1'b1; bus.Y_in = 1'b1; end
              S_T5: begin bus.C_out = 1'b1; bus.Z_in = 1'b1; bus.alu_op = ALU_ADD; end
              // T6 always spends a cycle; the PC only loads when the branch is taken.
              S_T6: begin bus.Zlow_out = bus.CON_out; bus.PC_in = bus.CON_out; end
              default: ;
            endcase
          end
          CLS_JR:   if (state == S_T3) begin bus.Gra = 1'b1; bus.Rout = 1'b1; bus.PC_in = 1'b1; end
          CLS_IN:   if (state == S_T3) begin bus.InPort_out = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1; end
          CLS_OUT:  if (state == S_T3) begin bus.Gra = 1'b1; bus.Rout = 1'b1; bus.OutPort_in = 1'b1; end
          CLS_MFHI: if (state == S_T3) begin bus.HI_out = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1; end
          CLS_MFLO: if (state == S_T3) begin bus.LO_out = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1; end
          default: ;
        endcase
      end
    endcase
  end

endmodule

// File: tb/tb_minisrc_control_unit.sv
// tb/tb_minisrc_control_unit.sv - self-checking bench for minisrc_control_unit
module tb_minisrc_control_unit;

  logic clk;
  logic clr;
  int   n_checks = 0;
  int   n_pass   = 0;
  bit   started  = 0;

  minisrc_control_unit_if bus ();

  minisrc_control_unit dut (
    .clk (clk),
    .clr (clr),
    .bus (bus.master)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  localparam logic [26:0] PCI = 27'h1 << 0,  IRI = 27'h1 << 1,  YI   = 27'h1 << 2,  ZI   = 27'h1 << 3;
  localparam logic [26:0] HII = 27'h1 << 4,  LOI = 27'h1 << 5,  MARI = 27'h1 << 6,  MDRI = 27'h1 << 7;
  localparam logic [26:0] OPI = 27'h1 << 8,  INC = 27'h1 << 9,  PCO  = 27'h1 << 10, ZHO  = 27'h1 << 11;
  localparam logic [26:0] ZLO = 27'h1 << 12, HIO = 27'h1 << 13, LOO  = 27'h1 << 14, MDRO = 27'h1 << 15;
  localparam logic [26:0] INPO = 27'h1 << 16, CO = 27'h1 << 17, RD   = 27'h1 << 18, WR   = 27'h1 << 19;
  localparam logic [26:0] GRA = 27'h1 << 20, GRB = 27'h1 << 21, GRC  = 27'h1 << 22, RIN  = 27'h1 << 23;
  localparam logic [26:0] ROUT = 27'h1 << 24, BAO = 27'h1 << 25, CONI = 27'h1 << 26;

  logic [26:0] act;
  assign act = {bus.CON_in, bus.BAout, bus.Rout, bus.Rin, bus.Grc, bus.Grb, bus.Gra, bus.Write,
                bus.Read, bus.C_out, bus.InPort_out, bus.MDR_out, bus.LO_out, bus.HI_out,
                bus.Zlow_out, bus.Zhigh_out, bus.PC_out, bus.IncPC, bus.OutPort_in, bus.MDR_in,
                bus.MAR_in, bus.LO_in, bus.HI_in, bus.Z_in, bus.Y_in, bus.IR_in, bus.PC_in};

  // Model: each instruction expands to a list of expected control words, one per cycle.
  typedef struct packed {
    logic [26:0] s;
    logic [4:0]  a;
    logic        c;   // strobes only fire if CON_out=1
  } word_t;

  typedef enum int {M_RST, M_RUN, M_HALT} mode_t;
  mode_t mode = M_RST;
  word_t q[$];
  bit    in_exec    = 0;
  bit    halt_after = 0;

  function automatic word_t w(logic [26:0] s, logic [4:0] a = 5'd0, logic c = 1'b0);
    word_t r;
    r.s = s; r.a = a; r.c = c;
    return r;
  endfunction

  task automatic push_fetch();
    q.push_back(w(PCO | MARI | INC | ZI));
    q.push_back(w(ZLO | PCI | RD | MDRI));
    q.push_back(w(MDRO | IRI));
  endtask

  task automatic push_exec(input logic [4:0] op);
    halt_after = 0;
    case (op)
      5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10, 5'd11: begin
        q.push_back(w(GRB | ROUT | YI)); q.push_back(w(GRC | ROUT | ZI, op)); q.push_back(w(ZLO | GRA | RIN));
      end
      5'd12, 5'd13, 5'd14: begin
        q.push_back(w(GRB | ROUT | YI));
        q.push_back(w(CO | ZI, (op == 5'd12) ? 5'd3 : (op == 5'd13) ? 5'd5 : 5'd6));
        q.push_back(w(ZLO | GRA | RIN));
      end
      5'd15, 5'd16: begin
        q.push_back(w(GRA | ROUT | YI)); q.push_back(w(GRB | ROUT | ZI, op));
        q.push_back(w(ZLO | LOI));       q.push_back(w(ZHO | HII));
      end
      5'd17, 5'd18: begin q.push_back(w(GRB | ROUT | ZI, op)); q.push_back(w(ZLO | GRA | RIN)); end
      5'd0, 5'd1, 5'd2: begin
        q.push_back(w(GRB | BAO | YI)); q.push_back(w(CO | ZI, 5'd3));
        if (op == 5'd1) q.push_back(w(ZLO | GRA | RIN));
        else begin
          q.push_back(w(ZLO | MARI));
          if (op == 5'd0) begin q.push_back(w(RD | MDRI)); q.push_back(w(MDRO | GRA | RIN)); end
          else            begin q.push_back(w(GRA | ROUT | MDRI)); q.push_back(w(WR)); end
        end
      end
      5'd19: begin
        q.push_back(w(GRA | ROUT | CONI)); q.push_back(w(PCO | YI));
        q.push_back(w(CO | ZI, 5'd3));     q.push_back(w(ZLO | PCI, 5'd0, 1'b1));
      end
      5'd20: q.push_back(w(GRA | ROUT | PCI));
      5'd22: q.push_back(w(INPO | GRA | RIN));
      5'd23: q.push_back(w(GRA | ROUT | OPI));
      5'd24: q.push_back(w(HIO | GRA | RIN));
      5'd25: q.push_back(w(LOO | GRA | RIN));
      5'd27: begin q.push_back(w(27'd0)); halt_after = 1; end
      default: q.push_back(w(27'd0));
    endcase
  endtask

  initial forever begin
    @(posedge clk);
    started = 1;
    if (!clr) begin
      mode = M_RST; q.delete(); in_exec = 0;
    end else if (mode == M_RST) begin
      mode = M_RUN; q.delete(); push_fetch(); in_exec = 0;
    end else if (mode == M_RUN) begin
      void'(q.pop_front());
      if (q.size() == 0) begin
        if (!in_exec) begin
          push_exec(bus.IR_Data[31:27]); in_exec = 1;
        end else if (halt_after || bus.Stop) begin
          mode = M_HALT;
        end else begin
          push_fetch(); in_exec = 0;
        end
      end
    end
  end

  initial forever begin
    logic [32:0] want, got;
    word_t e;
    @(negedge clk);
    if (started) begin
      want = '0;
      if (mode == M_RUN && q.size() > 0) begin
        e = q[0];
        want = {1'b1, e.a, (e.c && !bus.CON_out) ? 27'd0 : e.s};
      end
      got = {bus.Run, bus.alu_op, act};
      n_checks++;
      if (got === want) n_pass++;
      else $display("FAIL cycle t=%0t run/alu/strobes got=%h want=%h", $time, got, want);
    end
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s got=%h want=%h", nm, got, want);
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic run_op(input logic [4:0] op, input bit stop_mid);
    bit done;
    bus.IR_Data = {op, 27'($urandom)};
    bus.CON_out = 1'($urandom_range(0, 1));
    tick(3);
    if (stop_mid) bus.Stop = 1'b1;
    done = 0;
    for (int i = 0; i < 8 && !done; i++) begin
      tick();
      if (!bus.Run || (bus.PC_out && bus.MAR_in)) done = 1;
    end
    chk($sformatf("bound op=%0d", op), 32'(done), 32'd1);
    bus.Stop = 1'b0;
    if (!bus.Run) begin
      clr = 1'b0; tick();
      clr = 1'b1; tick();
    end
  endtask

  initial begin
    clr = 1'b0;
    bus.Stop = 1'b0;
    bus.CON_out = 1'b0;
    bus.IR_Data = 32'd0;

    tick(3);
    chk("reset strobes", 32'(act), 32'd0);
    chk("reset run", 32'(bus.Run), 32'd0);
    clr = 1'b1;
    chk("rst cycle run", 32'(bus.Run), 32'd0);
    tick();
    chk("T0 strobes", 32'({bus.PC_out, bus.MAR_in, bus.IncPC, bus.Z_in}), 32'hF);
    chk("T0 run", 32'(bus.Run), 32'd1);

    bus.IR_Data = 32'h19890000;
    tick(3);
    chk("add T3", 32'({bus.Grb, bus.Rout, bus.Y_in}), 32'd7);
    tick();
    chk("add T4", 32'({bus.Grc, bus.Rout, bus.Z_in}), 32'd7);
    chk("add T4 alu", 32'(bus.alu_op), 32'd3);
    tick();
    chk("add T5", 32'({bus.Zlow_out, bus.Gra, bus.Rin}), 32'd7);
    tick();
    chk("add next T0", 32'(bus.PC_out), 32'd1);

    bus.IR_Data = 32'h9B180019;
    bus.CON_out = 1'b1;
    tick(3);
    chk("br T3 CON_in", 32'(bus.CON_in), 32'd1);
    tick(2);
    chk("br T5 C_out", 32'(bus.C_out), 32'd1);
    chk("br T5 alu", 32'(bus.alu_op), 32'd3);
    tick();
    chk("br taken T6", 32'({bus.Zlow_out, bus.PC_in}), 32'd3);
    tick();
    bus.CON_out = 1'b0;
    tick(6);
    chk("br not taken T6", 32'({bus.Zlow_out, bus.PC_in}), 32'd0);
    tick();
    chk("br nt next T0", 32'(bus.PC_out), 32'd1);

    bus.IR_Data = 32'h01080045;
    tick(6);
    chk("ld T6", 32'({bus.Read, bus.MDR_in}), 32'd3);
    tick();
    chk("ld T7", 32'({bus.MDR_out, bus.Gra, bus.Rin}), 32'd7);
    bus.Stop = 1'b1;
    tick();
    chk("stop halt run", 32'(bus.Run), 32'd0);
    bus.Stop = 1'b0;
    tick(2);
    chk("halt sticky run", 32'(bus.Run), 32'd0);
    chk("halt strobes", 32'(act), 32'd0);

    clr = 1'b0; tick();
    clr = 1'b1; tick();
    bus.IR_Data = 32'hD8000000;
    tick(3);
    chk("halt T3 run", 32'(bus.Run), 32'd1);
    tick();
    chk("halt instr run", 32'(bus.Run), 32'd0);

    clr = 1'b0; tick();
    clr = 1'b1; tick();
    bus.IR_Data = 32'h80000000;
    tick(4);
    chk("mul T4", 32'({bus.Grb, bus.Rout, bus.Z_in}), 32'd7);
    chk("mul T4 alu", 32'(bus.alu_op), 32'd16);
    clr = 1'b0;
    tick();
    chk("abort strobes", 32'(act), 32'd0);
    chk("abort run", 32'(bus.Run), 32'd0);
    tick();
    chk("abort no HI_in", 32'(bus.HI_in), 32'd0);
    clr = 1'b1;
    tick();
    chk("restart T0", 32'({bus.Run, bus.PC_out}), 32'd3);

    for (int op = 0; op < 32; op++) run_op(5'(op), op == 2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
